// File: rtl/grant_priority_updater_if.sv
// Bundle between the grant-number generator / downstream and the priority updater.
// The master drives requests and handshake; the slave returns the priority order and grant.
interface grant_priority_updater_if #(
    parameter int CANDIDATE = 2
);
    localparam int IW = (CANDIDATE > 1) ? $clog2(CANDIDATE) : 1;

    logic [CANDIDATE-1:0] request_vec;
    logic [IW-1:0]        grant_number;
    logic                 grant_accept;
    logic                 grant_last;
    logic [IW-1:0]        priority_array [0:CANDIDATE-1];
    logic                 grant_valid;
    logic [IW-1:0]        grant_id;
    logic [CANDIDATE-1:0] grant_onehot;
    logic                 locked;

    modport master (
        output request_vec, grant_number, grant_accept, grant_last,
        input  priority_array, grant_valid, grant_id, grant_onehot, locked
    );

    modport slave (
        input  request_vec, grant_number, grant_accept, grant_last,
        output priority_array, grant_valid, grant_id, grant_onehot, locked
    );
endinterface

// File: rtl/grant_priority_updater.sv
// Keeps the LRU priority order for one crossbar output, maps grant_number to a requester,
// holds the grant across multi-beat transfers and demotes the served requester on its last beat.
module grant_priority_updater #(
    parameter int CANDIDATE = 2
) (
    input  logic clk,
    input  logic rst,
    grant_priority_updater_if.slave bus
);
    localparam int IW = (CANDIDATE > 1) ? $clog2(CANDIDATE) : 1;
    localparam logic [IW:0] LAST_POS = (IW+1)'(CANDIDATE - 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        locked_id_q, locked_id_d;
    logic [IW-1:0]        prio_q [0:CANDIDATE-1];
    logic [IW-1:0]        prio_d [0:CANDIDATE-1];

    logic                 number_in_range;
    logic [IW-1:0]        grant_id;
    logic                 grant_valid;
    logic                 do_rotate;
    logic [IW-1:0]        rot_pos;
    logic [IW-1:0]        locked_pos;
    logic [CANDIDATE-1:0] locked_match;

    // Non-power-of-2 requester counts leave grant_number codes with no array slot.
    assign number_in_range = ({1'b0, bus.grant_number} <= LAST_POS);

    always_comb begin
        locked_pos = '0;
        for (int i = 0; i < CANDIDATE; i++) begin
            if (locked_match[i]) begin
                locked_pos = IW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        locked_id_d = locked_id_q;
        do_rotate   = 1'b0;
        grant_id    = '0;
        grant_valid = 1'b0;
        rot_pos     = bus.grant_number;
        case (state_q)
            ST_UNLOCKED: begin
                if (number_in_range) begin
                    grant_id    = prio_q[bus.grant_number];
                    grant_valid = |bus.request_vec;
                end
                if (grant_valid && bus.grant_accept) begin
                    if (bus.grant_last) begin
                        do_rotate = 1'b1;
                    end else begin
                        state_d     = ST_LOCKED;
                        locked_id_d = grant_id;
                    end
                end
            end
            ST_LOCKED: begin
                grant_id    = locked_id_q;
                grant_valid = bus.request_vec[locked_id_q];
                rot_pos     = locked_pos;
                if (grant_valid && bus.grant_accept && bus.grant_last) begin
                    do_rotate = 1'b1;
                    state_d   = ST_UNLOCKED;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase
    end

    // Entries at or behind the served position slide up by one; the served ID goes last.
    genvar gi;
    generate
        for (gi = 0; gi < CANDIDATE; gi++) begin : g_slot
            localparam logic [IW:0] POS = (IW+1)'(gi);
            logic [IW-1:0] shifted;

            if (gi == CANDIDATE - 1) begin : g_tail
                assign shifted = grant_id;
            end else begin : g_body
                assign shifted = prio_q[gi+1];
            end

            assign prio_d[gi]              = (do_rotate && (POS >= {1'b0, rot_pos})) ? shifted : prio_q[gi];
            assign locked_match[gi]        = (prio_q[gi] == locked_id_q);
            assign bus.priority_array[gi]  = prio_q[gi];
            assign bus.grant_onehot[gi]    = grant_valid && (grant_id == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            locked_id_q <= '0;
            for (int i = 0; i < CANDIDATE; i++) begin
                prio_q[i] <= IW'(i);
            end
        end else begin
            state_q     <= state_d;
            locked_id_q <= locked_id_d;
            for (int i = 0; i < CANDIDATE; i++) begin
                prio_q[i] <= prio_d[i];
            end
        end
    end

    assign bus.grant_valid = grant_valid;
    assign bus.grant_id    = grant_id;
    assign bus.locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_grant_priority_updater.sv
// Bench for grant_priority_updater with four requesters, checked against a queue-based LRU model.
module tb_grant_priority_updater;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grant_priority_updater_if #(.CANDIDATE(N)) bus ();
    grant_priority_updater #(.CANDIDATE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    bit perm_en = 1'b0;

    int m_prio[$];
    bit m_locked;
    int m_lid;

    typedef struct {
        logic [N-1:0] req;
        logic [1:0]   gn;
        logic         acc;
        logic         last;
    } beat_t;

    function automatic void model_reset();
        m_prio   = {0, 1, 2, 3};
        m_locked = 1'b0;
        m_lid    = 0;
    endfunction

    function automatic void model_out(input logic [N-1:0] req, input int gn, output bit v, output int id);
        if (m_locked) begin
            id = m_lid;
            v  = req[m_lid];
        end else if (gn >= N) begin
            id = 0;
            v  = 1'b0;
        end else begin
            id = m_prio[gn];
            v  = |req;
        end
    endfunction

    function automatic void model_step(input logic [N-1:0] req, input int gn, input bit acc, input bit last);
        bit v;
        int id;
        int p;
        model_out(req, gn, v, id);
        if (!(v && acc)) return;
        if (last) begin
            p = gn;
            if (m_locked) begin
                foreach (m_prio[i]) if (m_prio[i] == m_lid) p = i;
            end
            m_prio.delete(p);
            m_prio.push_back(id);
            m_locked = 1'b0;
        end else if (!m_locked) begin
            m_locked = 1'b1;
            m_lid    = id;
        end
    endfunction

    function automatic string dut_arr();
        return $sformatf("{%0d,%0d,%0d,%0d}", bus.priority_array[0], bus.priority_array[1],
                         bus.priority_array[2], bus.priority_array[3]);
    endfunction

    function automatic string model_arr();
        return $sformatf("{%0d,%0d,%0d,%0d}", m_prio[0], m_prio[1], m_prio[2], m_prio[3]);
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic [1:0] g, input logic a, input logic l);
        bus.request_vec  = r;
        bus.grant_number = g;
        bus.grant_accept = a;
        bus.grant_last   = l;
    endtask

    // Whatever the traffic, the order must remain a permutation of the requester IDs.
    always @(negedge clk) begin
        logic [N-1:0] seen;
        if (perm_en && !rst) begin
            seen = '0;
            for (int i = 0; i < N; i++) begin
                if (!$isunknown(bus.priority_array[i])) seen[bus.priority_array[i]] = 1'b1;
            end
            total++;
            if (seen !== {N{1'b1}}) begin
                bad++;
                $display("FAIL permutation t=%0t got=%b required=%b", $time, seen, {N{1'b1}});
            end
        end
    end

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b required=0", bus.locked); end
        total++;
        if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b required=0", bus.grant_valid); end
        total++;
        if (bus.grant_onehot !== 4'b0000) begin bad++; $display("FAIL reset_onehot got=%b required=0000", bus.grant_onehot); end
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (bus.priority_array[i] !== 2'(i)) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL reset_array got=%s required={0,1,2,3}", dut_arr()); end
        rst = 1'b0;
        perm_en = 1'b1;
        drive('0, 2'd1, 1'b1, 1'b1);
        @(posedge clk); #1;
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (bus.priority_array[i] !== 2'(i)) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL idle_accept_array got=%s required={0,1,2,3}", dut_arr()); end
        total++;
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL idle_accept_locked got=%b required=0", bus.locked); end
    endtask

    task automatic test_rotate();
        bit ok;
        int exp1[N] = '{1, 2, 3, 0};
        int exp2[N] = '{1, 2, 0, 3};
        drive(4'b0101, 2'd0, 1'b1, 1'b1);
        @(negedge clk);
        total++;
        if (bus.grant_valid !== 1'b1) begin bad++; $display("FAIL rot1_valid got=%b required=1", bus.grant_valid); end
        total++;
        if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL rot1_id got=%0d required=0", bus.grant_id); end
        total++;
        if (bus.grant_onehot !== 4'b0001) begin bad++; $display("FAIL rot1_onehot got=%b required=0001", bus.grant_onehot); end
        model_step(4'b0101, 0, 1'b1, 1'b1);
        @(posedge clk); #1;
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (bus.priority_array[i] !== 2'(exp1[i])) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL rot1_array got=%s required={1,2,3,0}", dut_arr()); end

        drive(4'b1000, 2'd2, 1'b1, 1'b1);
        @(negedge clk);
        total++;
        if (bus.grant_id !== 2'd3) begin bad++; $display("FAIL rot2_id got=%0d required=3", bus.grant_id); end
        total++;
        if (bus.grant_onehot !== 4'b1000) begin bad++; $display("FAIL rot2_onehot got=%b required=1000", bus.grant_onehot); end
        model_step(4'b1000, 2, 1'b1, 1'b1);
        @(posedge clk); #1;
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (bus.priority_array[i] !== 2'(exp2[i])) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL rot2_array got=%s required={1,2,0,3}", dut_arr()); end
        drive('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_lock();
        beat_t seq[9] = '{
            '{4'b0100, 2'd1, 1'b1, 1'b0},
            '{4'b0111, 2'd0, 1'b1, 1'b0},
            '{4'b0111, 2'd0, 1'b1, 1'b0},
            '{4'b0111, 2'd0, 1'b1, 1'b0},
            '{4'b0111, 2'd0, 1'b1, 1'b1},
            '{4'b0100, 2'd3, 1'b1, 1'b0},
            '{4'b0011, 2'd0, 1'b1, 1'b1},
            '{4'b0011, 2'd1, 1'b1, 1'b0},
            '{4'b0100, 2'd0, 1'b1, 1'b1}
        };
        int exp_fin[N] = '{1, 0, 3, 2};
        bit v;
        int id;
        bit ok;
        logic [N-1:0] exp_oh;
        for (int c = 0; c < 9; c++) begin
            drive(seq[c].req, seq[c].gn, seq[c].acc, seq[c].last);
            @(negedge clk);
            model_out(seq[c].req, int'(seq[c].gn), v, id);
            exp_oh = v ? (4'b0001 << id) : 4'b0000;
            total++;
            if (bus.grant_valid !== v) begin bad++; $display("FAIL lock_valid beat=%0d got=%b required=%b", c, bus.grant_valid, v); end
            total++;
            if (bus.grant_id !== 2'(id)) begin bad++; $display("FAIL lock_id beat=%0d got=%0d required=%0d", c, bus.grant_id, id); end
            total++;
            if (bus.grant_onehot !== exp_oh) begin bad++; $display("FAIL lock_onehot beat=%0d got=%b required=%b", c, bus.grant_onehot, exp_oh); end
            model_step(seq[c].req, int'(seq[c].gn), seq[c].acc, seq[c].last);
            @(posedge clk); #1;
            total++;
            if (bus.locked !== m_locked) begin bad++; $display("FAIL lock_state beat=%0d got=%b required=%b", c, bus.locked, m_locked); end
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (bus.priority_array[i] !== 2'(m_prio[i])) ok = 1'b0;
            total++;
            if (!ok) begin bad++; $display("FAIL lock_array beat=%0d got=%s required=%s", c, dut_arr(), model_arr()); end
        end
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (bus.priority_array[i] !== 2'(exp_fin[i])) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL lock_final_array got=%s required={1,0,3,2}", dut_arr()); end
        drive('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [1:0]   g;
        logic         a;
        logic         l;
        bit v;
        int id;
        bit ok;
        logic [N-1:0] exp_oh;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            g = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 2) == 0);
            drive(r, g, a, l);
            @(negedge clk);
            model_out(r, int'(g), v, id);
            exp_oh = v ? (4'b0001 << id) : 4'b0000;
            total++;
            if (bus.grant_valid !== v) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b required=%b", c, bus.grant_valid, v); end
            total++;
            if (bus.grant_id !== 2'(id)) begin bad++; $display("FAIL rnd_id cyc=%0d got=%0d required=%0d", c, bus.grant_id, id); end
            total++;
            if (bus.grant_onehot !== exp_oh) begin bad++; $display("FAIL rnd_onehot cyc=%0d got=%b required=%b", c, bus.grant_onehot, exp_oh); end
            model_step(r, int'(g), a, l);
            @(posedge clk); #1;
            total++;
            if (bus.locked !== m_locked) begin bad++; $display("FAIL rnd_locked cyc=%0d got=%b required=%b", c, bus.locked, m_locked); end
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (bus.priority_array[i] !== 2'(m_prio[i])) ok = 1'b0;
            total++;
            if (!ok) begin bad++; $display("FAIL rnd_array cyc=%0d got=%s required=%s", c, dut_arr(), model_arr()); end
        end
        drive('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        bit ok;
        // Force a non-identity order first so the reset has something to undo.
        drive(4'b0001, 2'd0, 1'b1, 1'b1);
        @(negedge clk);
        model_step(4'b0001, 0, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(4'b0100, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        model_step(4'b0100, 1, 1'b1, 1'b0);
        @(posedge clk); #1;
        total++;
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL arst_prelock got=%b required=1", bus.locked); end
        drive('0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL arst_locked got=%b required=0", bus.locked); end
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (bus.priority_array[i] !== 2'(i)) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL arst_array got=%s required={0,1,2,3}", dut_arr()); end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        drive('0, '0, 1'b0, 1'b0);
        test_reset();
        test_rotate();
        test_lock();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grant_priority_updater.md
Name: grant_priority_updater

Overview:
- Sequential companion to the combinational grant-number generator in the crossbar arbiter.
- Owns the per-output-port `priority_array` that the generator consumes.
- Converts the generator's `grant_number` (a position in priority order) back to a requester ID and one-hot grant.
- Holds the grant across multi-beat transfers (lock). Demotes the served requester to lowest priority when its transfer completes (LRU round-robin).

Parameters:
- candidate, 2, number of requesters; must be >= 2. IW = $clog2(candidate).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- request_vec  in  candidate  per-requester request, bit i = requester i
- grant_number  in  IW  position in priority_array chosen by the generator; valid when not locked
- grant_accept  in  1  downstream consumed a beat from the granted requester this cycle
- grant_last  in  1  accepted beat is the final beat of the transfer
- priority_array  out  IW x [0:candidate-1]  registered priority order; index 0 is highest priority, entry = requester ID
- grant_valid  out  1  a grant is presented this cycle
- grant_id  out  IW  granted requester ID
- grant_onehot  out  candidate  one-hot of grant_id, gated by grant_valid (all zero when grant_valid=0)
- locked  out  1  state == LOCKED

Behaviour:
- Reset (async, immediate):
  - priority_array[i] = i
  - state = UNLOCKED, locked = 0, locked_id = 0
  - outputs follow the combinational rules below from the reset state
- States: UNLOCKED, LOCKED.
- UNLOCKED (combinational outputs):
  - grant_valid = |request_vec
  - grant_id = priority_array[grant_number]
- LOCKED (combinational outputs):
  - grant_id = locked_id
  - grant_valid = request_vec[locked_id]
  - grant_number is ignored
- fire = grant_valid & grant_accept. grant_accept while grant_valid=0 is ignored: no state or array change.
- UNLOCKED, fire & grant_last:
  - Rotate next edge: remove the entry at position grant_number, shift entries at positions grant_number+1..candidate-1 down by one, write grant_id to position candidate-1.
  - Stay UNLOCKED.
- UNLOCKED, fire & !grant_last:
  - Next edge: state = LOCKED, locked_id = grant_id. priority_array unchanged.
- LOCKED, fire & !grant_last: no change.
- LOCKED, fire & grant_last:
  - Next edge: locate the position p of locked_id in priority_array, apply the same rotation at p, state = UNLOCKED.
- LOCKED, request_vec[locked_id] deasserts:
  - grant_valid = 0, lock is held.
  - Only a last-beat fire or rst releases the lock. No timeout.
- Latency:
  - grant_id, grant_valid and grant_onehot are combinational from inputs and state; zero cycles.
  - priority_array updates one edge after the completing fire. The generator sees the new order on the following cycle.
- Invariant: priority_array is always a permutation of 0..candidate-1. The bench must check this every cycle.
- Rotation when p = candidate-1 leaves the array unchanged.
- grant_number >= candidate is out of range (non-power-of-2 candidate):
  - treat as no valid position: grant_valid forced 0, no update.
- Simultaneous fire & last with a request change in the same cycle: the update uses the current-cycle grant_id. New requests take effect next cycle.

Test Plan (candidate=4):
1. Pulse rst -> priority_array = {0,1,2,3}, locked=0, grant_valid=0 with request_vec=0; grant_accept=1 with no request -> array unchanged.
2. From reset: request_vec=4'b0101, grant_number=0, grant_accept=1, grant_last=1 -> grant_id=0, grant_onehot=4'b0001 same cycle; next cycle priority_array={1,2,3,0}.
3. From {1,2,3,0}: request_vec=4'b1000, grant_number=2, grant_accept=1, grant_last=1 -> grant_id=3; next cycle priority_array={1,2,0,3}.
4. Lock hold: request_vec=4'b0100, grant_number=1 -> grant_id=2.
   - Accept with last=0 -> locked=1.
   - Next 3 cycles: drive grant_number=0 and request_vec=4'b0111 with accepts; grant_id stays 2, array unchanged.
   - Accept with last=1 -> next cycle locked=0 and requester 2 moved to position 3.
5. While locked on ID 2: drop request_vec[2] -> grant_valid=0, grant_onehot=0; accept and last are ignored, locked stays 1. Reassert, then fire with last -> unlock.
6. Assert rst mid-lock between clock edges -> locked=0 and priority_array={0,1,2,3} immediately, without waiting for a clk edge.
